// File: rtl/pe_array_64.sv
// pe_array_64: 64-column systolic Smith-Waterman stripe scorer with X-drop early
// termination. Reports the stripe maximum, its row, and the row where the next stripe starts.
module pe_array_64 #(
    parameter int MATCH    = 2,
    parameter int MISMATCH = 1,
    parameter int GAP      = 1,
    parameter int XDROP    = 20
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_B,
    input  logic [1:0]   i_A,
    output logic         o_stripe_end,
    output logic [9:0]   o_start_position,
    output logic [9:0]   o_end_position,
    output logic [13:0]  o_max_score_stripe
);

    localparam int         NPE        = 64;
    localparam logic [9:0] ROW_SAT    = 10'd1023;
    localparam logic [5:0] DRAIN_LAST = 6'd63;

    // Signed evaluation so negative candidates clamp to zero; result saturates at 14 bits.
    function automatic logic [13:0] cell_score(
        input logic [1:0]  a,
        input logic [1:0]  b,
        input logic [13:0] diag,
        input logic [13:0] up,
        input logic [13:0] left
    );
        logic signed [16:0] s_diag;
        logic signed [16:0] s_up;
        logic signed [16:0] s_left;
        logic signed [16:0] best;
        s_diag = $signed({3'b000, diag}) + ((a == b) ? 17'(MATCH) : -17'(MISMATCH));
        s_up   = $signed({3'b000, up})   - 17'(GAP);
        s_left = $signed({3'b000, left}) - 17'(GAP);
        best   = 17'sd0;
        best   = (s_diag > best) ? s_diag : best;
        best   = (s_up   > best) ? s_up   : best;
        best   = (s_left > best) ? s_left : best;
        return (best > 17'sd16383) ? 14'h3FFF : best[13:0];
    endfunction

    // a_r/v_r/row_r[c] carry what PE c just scored, which PE c+1 scores next cycle
    logic [1:0]     a_r   [NPE-1];
    logic [NPE-2:0] v_r;
    logic [9:0]     row_r [NPE-1];
    logic [13:0]    h_r   [NPE];
    logic [13:0]    d_r   [NPE];

    logic [9:0]  row_cnt_r;
    logic [5:0]  drain_r;
    logic        end_r;
    logic [13:0] max_r;
    logic [9:0]  end_row_r;
    logic [13:0] p63_max_r;
    logic [9:0]  p63_row_r;
    logic [9:0]  start_r;

    logic [1:0]     a_in_s   [NPE];
    logic [NPE-1:0] v_in_s;
    logic [9:0]     row_in_s [NPE];
    logic [13:0]    left_s   [NPE];
    logic [13:0]    h_new_s  [NPE];

    logic        sample_s;
    logic        saturated_s;
    logic [13:0] cell_best_s;
    logic [9:0]  cell_row_s;
    logic        take_s;
    logic [13:0] wf_max_s;
    logic [13:0] max_nxt_s;
    logic [9:0]  end_row_nxt_s;
    logic        p63_hit_s;
    logic [13:0] p63_max_nxt_s;
    logic [9:0]  p63_row_nxt_s;
    logic [9:0]  start_nxt_s;
    logic        xdrop_s;
    logic        end_cond_s;

    // Stripe control: row sampling gate and counter saturation.
    always_comb begin
        saturated_s = (row_cnt_r == ROW_SAT);
        sample_s    = i_start && !end_r && !saturated_s;
    end

    // PE inputs and cell scores; PE0 sees the fresh query base and a zero left neighbour.
    always_comb begin
        a_in_s[0]   = i_A;
        v_in_s[0]   = sample_s;
        row_in_s[0] = row_cnt_r;
        left_s[0]   = 14'd0;
        for (int c = 1; c < NPE; c++) begin
            a_in_s[c]   = a_r[c-1];
            v_in_s[c]   = v_r[c-1];
            row_in_s[c] = row_r[c-1];
            left_s[c]   = h_r[c-1];
        end
        for (int c = 0; c < NPE; c++) begin
            h_new_s[c] = cell_score(a_in_s[c], i_B[2*c +: 2], d_r[c], h_r[c], left_s[c]);
        end
    end

    // Best new cell this cycle (ties favour higher PE = earlier row) and wavefront maximum.
    always_comb begin
        cell_best_s = 14'd0;
        cell_row_s  = 10'd0;
        wf_max_s    = 14'd0;
        take_s      = 1'b0;
        for (int c = 0; c < NPE; c++) begin
            take_s      = v_in_s[c] && (h_new_s[c] >= cell_best_s);
            cell_best_s = take_s ? h_new_s[c]  : cell_best_s;
            cell_row_s  = take_s ? row_in_s[c] : cell_row_s;
            wf_max_s    = (h_r[c] > wf_max_s) ? h_r[c] : wf_max_s;
        end
    end

    // Next maxima, start position and the stripe end condition.
    always_comb begin
        max_nxt_s     = (cell_best_s > max_r) ? cell_best_s : max_r;
        end_row_nxt_s = (cell_best_s > max_r) ? cell_row_s  : end_row_r;
        p63_hit_s     = v_in_s[NPE-1] && (h_new_s[NPE-1] > p63_max_r);
        p63_max_nxt_s = p63_hit_s ? h_new_s[NPE-1]  : p63_max_r;
        p63_row_nxt_s = p63_hit_s ? row_in_s[NPE-1] : p63_row_r;
        start_nxt_s   = (p63_max_nxt_s != 14'd0) ? p63_row_nxt_s : end_row_nxt_s;
        xdrop_s       = (({4'd0, wf_max_s} + 18'(XDROP)) < {4'd0, max_r});
        end_cond_s    = (row_cnt_r >= 10'd64) &&
                        (xdrop_s || (saturated_s && (drain_r == DRAIN_LAST)));
    end

    // Systolic pipeline: cleared between stripes, frozen once the stripe has ended.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_start) begin
            v_r <= {(NPE-1){1'b0}};
            for (int c = 0; c < NPE-1; c++) begin
                a_r[c]   <= 2'd0;
                row_r[c] <= 10'd0;
            end
            for (int c = 0; c < NPE; c++) begin
                h_r[c] <= 14'd0;
                d_r[c] <= 14'd0;
            end
        end else if (!end_r) begin
            v_r <= v_in_s[NPE-2:0];
            for (int c = 0; c < NPE-1; c++) begin
                a_r[c]   <= a_in_s[c];
                row_r[c] <= row_in_s[c];
            end
            for (int c = 0; c < NPE; c++) begin
                if (v_in_s[c]) begin
                    h_r[c] <= h_new_s[c];
                    d_r[c] <= left_s[c];
                end
            end
        end
    end

    // Row/drain counters, maxima and result registers.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_start) begin
            row_cnt_r <= 10'd0;
            drain_r   <= 6'd0;
            end_r     <= 1'b0;
            max_r     <= 14'd0;
            end_row_r <= 10'd0;
            p63_max_r <= 14'd0;
            p63_row_r <= 10'd0;
            start_r   <= 10'd0;
        end else if (!end_r) begin
            if (sample_s) begin
                row_cnt_r <= row_cnt_r + 10'd1;
            end
            if (saturated_s && (drain_r != DRAIN_LAST)) begin
                drain_r <= drain_r + 6'd1;
            end
            end_r     <= end_cond_s;
            max_r     <= max_nxt_s;
            end_row_r <= end_row_nxt_s;
            p63_max_r <= p63_max_nxt_s;
            p63_row_r <= p63_row_nxt_s;
            start_r   <= start_nxt_s;
        end
    end

    assign o_stripe_end       = end_r;
    assign o_max_score_stripe = max_r;
    assign o_end_position     = end_row_r;
    assign o_start_position   = start_r;

endmodule

// File: tb/tb_pe_array_64.sv
// Directed, table-driven bench for pe_array_64: whole-stripe scenarios with
// hand-derived results, restart between stripes, freeze after end, reset mid-stripe.
module tb_pe_array_64;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_start;
    logic [127:0] i_B;
    logic [1:0]   i_A;
    logic         o_stripe_end;
    logic [9:0]   o_start_position;
    logic [9:0]   o_end_position;
    logic [13:0]  o_max_score_stripe;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pe_array_64 dut (
        .i_clk              (clk),
        .i_rst              (i_rst),
        .i_start            (i_start),
        .i_B                (i_B),
        .i_A                (i_A),
        .o_stripe_end       (o_stripe_end),
        .o_start_position   (o_start_position),
        .o_end_position     (o_end_position),
        .o_max_score_stripe (o_max_score_stripe)
    );

    typedef struct {
        string name;
        int    kind;
        int    exp_max;
        int    exp_end;
        int    exp_start;
        int    end_lo;
        int    end_hi;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_end"},   int'(o_stripe_end), 0);
        chk({name, "_max"},   int'(o_max_score_stripe), 0);
        chk({name, "_endp"},  int'(o_end_position), 0);
        chk({name, "_start"}, int'(o_start_position), 0);
    endtask

    // Reference row B for each scenario kind.
    function automatic logic [127:0] make_b(input int kind);
        logic [127:0] b;
        logic [9:0]   pat;
        pat = 10'b1010010110;
        b   = 128'd0;
        for (int c = 0; c < 64; c++) begin
            case (kind)
                0:       b[2*c +: 2] = 2'(c % 3);
                1:       b[2*c +: 2] = 2'd1;
                2:       b[2*c +: 2] = (c < 10) ? {1'b0, pat[c]} : 2'd2;
                3:       b[2*c +: 2] = (c < 10) ? 2'd0 : ((c >= 60) ? 2'd1 : 2'd2);
                default: b[2*c +: 2] = 2'd0;
            endcase
        end
        return b;
    endfunction

    // Query base for a given row of each scenario; 2'd3 never appears in kinds 0, 2, 3 B rows.
    function automatic logic [1:0] get_a(input int kind, input int row, input logic [127:0] b);
        case (kind)
            0:       return (row < 64) ? b[2*row +: 2] : 2'd3;
            1:       return 2'd0;
            2:       return (row >= 10 && row < 20) ? b[2*(row-10) +: 2] : 2'd3;
            3:       return (row >= 10 && row < 20) ? 2'd0 :
                            ((row >= 50 && row < 54) ? 2'd1 : 2'd3);
            default: return 2'd0;
        endcase
    endfunction

    task automatic clear_stripe(input string name);
        i_start = 1'b0;
        @(posedge clk);
        #1;
        chk_zero(name);
    endtask

    // Feed rows until o_stripe_end rises; edges = posedges seen (1200 means it never rose).
    task automatic run_vec(input int kind, output int edges);
        logic done;
        edges = 0;
        done  = 1'b0;
        while (!done && edges < 1200) begin
            i_A     = get_a(kind, edges, i_B);
            i_start = 1'b1;
            @(posedge clk);
            #1;
            edges++;
            done = o_stripe_end;
        end
    endtask

    task automatic check_results(input vec_t v, input string tag);
        chk({v.name, tag, "_max"},   int'(o_max_score_stripe), v.exp_max);
        chk({v.name, tag, "_endp"},  int'(o_end_position),     v.exp_end);
        chk({v.name, tag, "_start"}, int'(o_start_position),   v.exp_start);
    endtask

    initial begin
        int edges;

        vecs[0] = '{name: "identical", kind: 0, exp_max: 128, exp_end: 63, exp_start: 63, end_lo: 130,  end_hi: 200};
        vecs[1] = '{name: "mismatch",  kind: 1, exp_max: 0,   exp_end: 0,  exp_start: 0,  end_lo: 1087, end_hi: 1087};
        vecs[2] = '{name: "short",     kind: 2, exp_max: 20,  exp_end: 19, exp_start: 19, end_lo: 1087, end_hi: 1087};
        vecs[3] = '{name: "twoseg",    kind: 3, exp_max: 20,  exp_end: 19, exp_start: 53, end_lo: 1087, end_hi: 1087};

        i_rst   = 1'b1;
        i_start = 1'b0;
        i_A     = 2'd0;
        i_B     = 128'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        i_rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            clear_stripe({vecs[v].name, "_restart"});
            i_B = make_b(vecs[v].kind);
            run_vec(vecs[v].kind, edges);
            chk_range({vecs[v].name, "_end_cycle"}, edges, vecs[v].end_lo, vecs[v].end_hi);
            check_results(vecs[v], "");
            // results must hold while further rows arrive
            for (int k = 0; k < 6; k++) begin
                i_A = 2'($urandom_range(0, 3));
                @(posedge clk);
                #1;
            end
            chk({vecs[v].name, "_hold_end"}, int'(o_stripe_end), 1);
            check_results(vecs[v], "_hold");
        end

        // Reset in the middle of a stripe, then a fresh rerun of the same stripe.
        clear_stripe("midrst_pre");
        i_B = make_b(2);
        for (int r = 0; r <= 30; r++) begin
            i_A     = get_a(2, r, i_B);
            i_start = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("midrst_running_max",  int'(o_max_score_stripe), 20);
        chk("midrst_running_endp", int'(o_end_position), 19);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("midrst");
        i_rst = 1'b0;
        run_vec(2, edges);
        chk_range("midrst_rerun_end_cycle", edges, vecs[2].end_lo, vecs[2].end_hi);
        check_results(vecs[2], "_rerun");

        clear_stripe("final_restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_array_64.md
PE_ARRAY_64 -- requirements
Module: pe_array_64

Interface
REQ-001 SHALL have parameter MATCH, default 2, meaning score added when i_A equals the column base.
REQ-002 SHALL have parameter MISMATCH, default 1, meaning score subtracted when i_A differs from the column base.
REQ-003 SHALL have parameter GAP, default 1, meaning linear gap penalty subtracted per gap.
REQ-004 SHALL have parameter XDROP, default 20, meaning early-termination threshold below the stripe maximum.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port i_start, input, 1 bit: 1 = feed one A symbol this cycle; 0 = clear stripe state.
REQ-008 SHALL have port i_B, input, 128 bits: 64 reference bases, column c at bits [2c+1:2c]; held stable for a whole stripe.
REQ-009 SHALL have port i_A, input, 2 bits: the query base for the current row.
REQ-010 SHALL have port o_stripe_end, output, 1 bit: stripe finished; result outputs valid.
REQ-011 SHALL have port o_start_position, output, 10 bits: row offset, relative to stripe start, where the next stripe begins.
REQ-012 SHALL have port o_end_position, output, 10 bits: relative row of the maximum-score cell.
REQ-013 SHALL have port o_max_score_stripe, output, 14 bits: maximum cell score in the stripe.

Function
REQ-014 SHALL implement 64 processing elements (PE c = column c) as a systolic array; i_A enters PE0 and shifts one PE per cycle, so PE c scores row r at cycle r+c after row r is sampled.
REQ-015 SHALL compute per cell H = max(0, Hdiag + (A==B ? MATCH : -MISMATCH), Hup - GAP, Hleft - GAP), with Hleft = 0 for PE0 and Hup = 0 for row 0.
REQ-016 SHALL hold scores as 14-bit unsigned values, saturating at 16383, and evaluate intermediate arithmetic signed so that negatives clamp to 0.
REQ-017 SHALL keep a 10-bit row counter, incremented per sampled i_A while i_start=1 and saturating at 1023.
REQ-018 SHALL track the stripe maximum; on a strictly greater cell, SHALL update max score and end row, with ties keeping the earlier row.
REQ-019 SHALL record the row of the highest PE63 score, ties keeping the earlier row, as o_start_position; if PE63 never scored above 0, o_start_position SHALL equal o_end_position.
REQ-020 SHALL compute the wavefront maximum each cycle as the max H over all 64 PEs.
REQ-021 SHALL end a stripe once at least 64 rows are sampled and either (a) wavefront max + XDROP < stripe max, or (b) the row counter saturated and 63 drain cycles elapsed.
REQ-022 SHALL register o_stripe_end one cycle after the end condition; once set it stays 1 and results freeze while i_start=1, with further i_A ignored.
REQ-023 SHALL clear all PE scores, counters, maxima and o_stripe_end at the next edge whenever i_start=0; a stripe restarts on the first cycle with i_start=1.
REQ-024 SHALL give i_rst priority over i_start.
REQ-025 SHALL not carry scores from one stripe to the next; each stripe is an independent local alignment.

Reset
REQ-026 SHALL, on i_rst=1 at a rising edge, set all outputs to 0 and clear all PE scores, the shift pipeline, counters and maxima.
REQ-027 SHALL apply reset mid-stripe to abort the stripe with no result held; the next stripe starts once i_start=1 after reset release.

Verification
REQ-028 Identical: i_B = 64 bases, i_A rows 0..63 equal i_B, then random -> o_max_score_stripe=128, o_end_position=63, o_start_position=63, o_stripe_end asserted before row 200.
REQ-029 All mismatch: i_B all 2'b01, i_A all 2'b00 for 1024+ cycles -> max 0, o_stripe_end asserted 64 cycles after counter saturates, end=start=0.
REQ-030 Short match: i_A rows 10..19 equal B columns 0..9, else mismatching -> max 20, end 19, start 19.
REQ-031 Restart: after o_stripe_end, i_start=0 for 1 cycle -> o_stripe_end=0 and outputs=0 next cycle; a new stripe scores independently.
REQ-032 Reset mid-stripe at row 30 -> all outputs 0 the following cycle; the rerun stripe gives results identical to a fresh run.
